// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C controller datapath blocks.
package i2c_pkg;

  // Shift engine control state.
  typedef enum logic {
    StIdle,
    StActive
  } shift_state_t;

  // Bits needed to hold a count of 0..width inclusive.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/shift_bit_counter.sv
// Remaining-bit counter for the shift engine: loads the frame length,
// decrements once per sample and flags the final bit.
module shift_bit_counter #(
  parameter int unsigned CW = 4
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          load,
  input  logic [CW-1:0] load_value,
  input  logic          dec,
  output logic          last
);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: a load wins over a decrement; never wraps below zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_value;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == CW'(1));

endmodule

// File: rtl/shift_engine.sv
// Serial/parallel shift engine for I2C byte, address and ACK phases.
// Frame length and bit order are latched per frame at load time.
module shift_engine
  import i2c_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter logic        IDLE_LEVEL = 1'b1,
  parameter int unsigned CW         = cnt_width(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic [CW-1:0]    nbits,
  input  logic             msb_first,
  input  logic             drive,
  input  logic             sample,
  input  logic             sin,
  output logic             sout,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rx_data
);

  localparam int unsigned IW = $clog2(WIDTH);

  shift_state_t     state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    nbits_q, nbits_d;
  logic             order_q, order_d;
  logic             sout_q, sout_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] rx_q, rx_d;

  logic [CW-1:0]    nbits_clamped;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] mask;
  logic             cnt_load, cnt_dec, cnt_last;

  // Head bit of a frame of length n in the given order.
  function automatic logic head_of(input logic [WIDTH-1:0] v, input logic [CW-1:0] n,
                                   input logic msb);
    logic [IW-1:0] idx;
    idx = IW'(n - 1'b1);
    return msb ? v[idx] : v[0];
  endfunction

  // Out-of-range lengths (0 or > WIDTH) mean a full-width frame.
  always_comb begin
    nbits_clamped = nbits;
    if ((nbits == '0) || (32'(nbits) > WIDTH)) begin
      nbits_clamped = CW'(WIDTH);
    end
  end

  // Shift in sin at the tail of the frame; mask keeps only the live frame bits.
  always_comb begin
    shifted = '0;
    if (order_q) begin
      shifted = {shreg_q[WIDTH-2:0], sin};
    end else begin
      shifted = shreg_q >> 1;
      shifted[IW'(nbits_q - 1'b1)] = sin;
    end
    mask = {WIDTH{1'b1}} >> (WIDTH - 32'(nbits_q));
  end

  // Control and datapath next state; abort beats load and the final sample.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    nbits_d  = nbits_q;
    order_d  = order_q;
    sout_d   = sout_q;
    rx_d     = rx_q;
    done_d   = 1'b0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    if (abort) begin
      state_d = StIdle;
    end else if (state_q == StIdle) begin
      if (load_valid) begin
        shreg_d  = load_data;
        nbits_d  = nbits_clamped;
        order_d  = msb_first;
        sout_d   = head_of(load_data, nbits_clamped, msb_first);
        cnt_load = 1'b1;
        state_d  = StActive;
      end
    end else begin
      if (sample) begin
        shreg_d = shifted;
        cnt_dec = 1'b1;
        if (cnt_last) begin
          rx_d    = shifted & mask;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      // sout holds through the final sample even if drive is also set.
      if (drive && !(sample && cnt_last)) begin
        sout_d = head_of(shreg_d, nbits_q, order_q);
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      shreg_q <= '0;
      nbits_q <= CW'(WIDTH);
      order_q <= 1'b1;
      sout_q  <= IDLE_LEVEL;
      done_q  <= 1'b0;
      rx_q    <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      nbits_q <= nbits_d;
      order_q <= order_d;
      sout_q  <= sout_d;
      done_q  <= done_d;
      rx_q    <= rx_d;
    end
  end

  shift_bit_counter #(
    .CW(CW)
  ) u_counter (
    .clock      (clock),
    .reset      (reset),
    .load       (cnt_load),
    .load_value (nbits_clamped),
    .dec        (cnt_dec),
    .last       (cnt_last)
  );

  assign load_ready = (state_q == StIdle) & ~abort;
  assign busy       = (state_q == StActive);
  assign done       = done_q;
  assign rx_data    = rx_q;
  assign sout       = sout_q;

endmodule

// File: tb/tb_shift_engine.sv
// Self-checking bench for shift_engine: directed phases plus random frames
// checked against a frame-level model of transmitted and received bits.
module tb_shift_engine;

  localparam int W   = 8;
  localparam int CWT = 4;

  logic           clock = 1'b0;
  logic           reset;
  logic           load_valid;
  logic           load_ready;
  logic [W-1:0]   load_data;
  logic [CWT-1:0] nbits;
  logic           msb_first;
  logic           drive;
  logic           sample;
  logic           sin;
  logic           sout;
  logic           abort;
  logic           busy;
  logic           done;
  logic [W-1:0]   rx_data;

  int n_chk = 0;
  int n_bad = 0;
  logic [W-1:0] prev_rx;

  shift_engine #(
    .WIDTH      (W),
    .IDLE_LEVEL (1'b1)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .nbits      (nbits),
    .msb_first  (msb_first),
    .drive      (drive),
    .sample     (sample),
    .sin        (sin),
    .sout       (sout),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .rx_data    (rx_data)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Bit k of a frame in transmission/reception order.
  function automatic logic frame_bit(input logic [W-1:0] d, input int n, input bit msb,
                                     input int k);
    return msb ? d[n-1-k] : d[k];
  endfunction

  function automatic int clamp_len(input int nb);
    return (nb == 0 || nb > W) ? W : nb;
  endfunction

  task automatic quiet();
    load_valid = 1'b0;
    drive      = 1'b0;
    sample     = 1'b0;
    abort      = 1'b0;
    sin        = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_sout"}, sout, 1);
    chk({tag, "_ready"}, load_ready, 1);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rx"}, rx_data, 0);
  endtask

  // mode 0: sample/drive alternate; 1: random strobes; 2: drive+sample together.
  task automatic run_frame(input logic [W-1:0] data, input int nb, input bit msb,
                           input logic [W-1:0] rxval, input int mode, input bit hold_lv);
    int   n;
    int   k;
    int   cyc;
    bit   fin;
    bit   d;
    bit   s;
    logic sexp;
    logic [W-1:0] rx_exp;
    n      = clamp_len(nb);
    rx_exp = rxval & W'((1 << n) - 1);
    k      = 0;
    cyc    = 0;
    fin    = 1'b0;
    @(negedge clock);
    load_data  = data;
    nbits      = CWT'(nb);
    msb_first  = msb;
    load_valid = 1'b1;
    #1 chk("ready_idle", load_ready, 1);
    @(negedge clock);
    load_valid = hold_lv;
    if (hold_lv) begin
      load_data = ~data;
      nbits     = CWT'($urandom_range(1, 15));
      msb_first = ~msb;
    end
    sexp = frame_bit(data, n, msb, 0);
    chk("load_busy", busy, 1);
    chk("load_sout", sout, sexp);
    chk("active_ready", load_ready, 0);
    while (!fin && cyc < 200) begin
      case (mode)
        0:       begin s = (cyc % 2 == 0); d = ~s; end
        2:       begin s = 1'b1; d = 1'b1; end
        default: begin s = 1'($urandom_range(0, 1)); d = 1'($urandom_range(0, 1)); end
      endcase
      drive  = d;
      sample = s;
      sin    = s ? frame_bit(rxval, n, msb, k) : 1'($urandom_range(0, 1));
      @(negedge clock);
      cyc++;
      if (s) k++;
      if (d && k < n) sexp = frame_bit(data, n, msb, k);
      if (k == n) begin
        fin = 1'b1;
        chk("done_pulse", done, 1);
        chk("rx_data", rx_data, rx_exp);
        chk("done_busy", busy, 0);
        chk("done_ready", load_ready, 1);
        chk("done_sout", sout, sexp);
      end else begin
        chk("mid_done", done, 0);
        chk("mid_busy", busy, 1);
        chk("mid_sout", sout, sexp);
      end
    end
    quiet();
    chk("frame_finished", fin, 1);
    @(negedge clock);
    chk("done_one_cycle", done, 0);
    chk("rx_held", rx_data, rx_exp);
    prev_rx = rx_exp;
  endtask

  initial begin
    quiet();
    load_data = '0;
    nbits     = '0;
    msb_first = 1'b1;
    reset     = 1'b1;
    repeat (2) @(negedge clock);
    check_reset_state("reset");
    reset = 1'b0;

    // Byte MSB-first, byte LSB-first, ACK bit.
    run_frame(8'hA5, 8, 1'b1, 8'h3C, 0, 1'b0);
    run_frame(8'h0F, 8, 1'b0, 8'hC3, 0, 1'b0);
    run_frame(8'h00, 1, 1'b1, 8'h01, 0, 1'b0);
    // Length 0 treated as full width; load offered while active is ignored.
    run_frame(8'h96, 0, 1'b1, 8'h5A, 1, 1'b0);
    run_frame(8'h3B, 7, 1'b0, 8'h71, 1, 1'b1);
    run_frame(8'hE4, 8, 1'b1, 8'h2D, 2, 1'b0);
    run_frame(8'h1C, 5, 1'b0, 8'h0B, 2, 1'b0);

    for (int i = 0; i < 30; i++) begin
      run_frame(W'($urandom), $urandom_range(0, 15), 1'($urandom_range(0, 1)), W'($urandom),
                $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    // Abort after three samples.
    @(negedge clock);
    load_data  = 8'h55;
    nbits      = 4'd8;
    msb_first  = 1'b1;
    load_valid = 1'b1;
    @(negedge clock);
    load_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample = 1'b1;
      sin    = 1'b1;
      @(negedge clock);
    end
    sample = 1'b1;
    abort  = 1'b1;
    @(negedge clock);
    quiet();
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_rx", rx_data, prev_rx);
    chk("abort_sout", sout, 0);

    // Abort with a load offered in idle: not accepted.
    load_data  = 8'hFF;
    nbits      = 4'd3;
    load_valid = 1'b1;
    abort      = 1'b1;
    #1 chk("abort_ready", load_ready, 0);
    @(negedge clock);
    quiet();
    chk("abort_noload", busy, 0);

    // Abort on the final sample of an ACK frame suppresses done.
    load_data  = 8'h01;
    nbits      = 4'd1;
    load_valid = 1'b1;
    @(negedge clock);
    load_valid = 1'b0;
    chk("ack_sout", sout, 1);
    sample = 1'b1;
    abort  = 1'b1;
    sin    = 1'b0;
    @(negedge clock);
    quiet();
    chk("abort_last_done", done, 0);
    chk("abort_last_busy", busy, 0);
    chk("abort_last_rx", rx_data, prev_rx);

    // Reset in the middle of a frame.
    load_data  = 8'h00;
    nbits      = 4'd8;
    load_valid = 1'b1;
    @(negedge clock);
    load_valid = 1'b0;
    sample     = 1'b1;
    @(negedge clock);
    sample = 1'b0;
    reset  = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_reset_state("midreset");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/shift_engine.md
# shift_engine

Parametrised serial/parallel shift engine for the I2C controller's byte and ACK phases. It accepts a parallel frame through a valid/ready handshake and presents it one bit at a time on `sout`, updated on external drive strobes. It captures `sin` on external sample strobes, counts bits, and returns the received frame with a one-cycle `done` pulse. Frame length (1..WIDTH) and bit order are selected per frame, so a single engine serves 8-bit data, 7-bit address and 1-bit ACK phases.

## Interface
- `WIDTH`, 8, maximum frame length in bits (≥2)
- `IDLE_LEVEL`, 1'b1, value of `sout` after reset (released SDA)
- `CW`, $clog2(WIDTH+1), width of the bit counter and `nbits` (derived, not overridden)

- `clock`  in  1  single clock; all state updates on its rising edge
- `reset`  in  1  synchronous, active-high
- `load_valid`  in  1  parallel frame offered
- `load_ready`  out  1  engine accepts frame; = (state==IDLE) & ~abort
- `load_data`  in  WIDTH  frame to transmit; frame occupies bits [nbits-1:0]
- `nbits`  in  CW  frame length, latched at load; 0 or >WIDTH → WIDTH
- `msb_first`  in  1  bit order, latched at load; 1 = bit nbits-1 first
- `drive`  in  1  strobe: update `sout` to the current head bit
- `sample`  in  1  strobe: capture `sin`, shift, count one bit
- `sin`  in  1  serial input
- `sout`  out  1  serial output, registered
- `abort`  in  1  cancel current frame
- `busy`  out  1  state==ACTIVE
- `done`  out  1  one-cycle pulse, frame complete
- `rx_data`  out  WIDTH  received frame, zero above nbits; held until next done

## Operation
- States: IDLE, ACTIVE.
- IDLE:
  - On `load_valid & load_ready`: `shreg` ← load_data; `cnt` ← nbits_l (clamped); `order` ← msb_first; `sout` ← head(load_data); go to ACTIVE.
  - `drive` and `sample` are ignored.
- Head bit: `shreg[nbits_l-1]` if MSB-first, `shreg[0]` if LSB-first.
- ACTIVE, `sample`:
  - MSB-first: `shreg` shifts left; `sin` enters bit 0.
  - LSB-first: `shreg[nbits_l-1:0]` shifts right; `sin` enters bit nbits_l-1.
  - `cnt` decrements.
- ACTIVE, `drive`: `sout` ← head of the post-sample `shreg`.
  - If `sample` and `drive` occur in the same cycle, the shift is applied first and `sout` takes the new head.
- Final `sample` (cnt==1):
  - `rx_data` ← shifted `shreg` masked to nbits_l.
  - `done` ← 1; next state IDLE.
  - `sout` holds its value.
- `abort` (any state):
  - Next state IDLE; no `done`; `rx_data` and `sout` unchanged.
  - Overrides a simultaneous final sample and a simultaneous load.
- Bits of `shreg` above nbits_l are don't-care internally and never visible on `rx_data`.
- `load_valid` while ACTIVE: not accepted; the source holds `load_data` until ready.

## Timing
- Reset values: `sout`=IDLE_LEVEL, `load_ready`=1, `busy`=0, `done`=0, `rx_data`=0, `cnt`=0, state IDLE.
- Load accepted at edge t: `busy`=1 and `sout`=first bit from t+1. The first bit is valid before any drive strobe.
- Drive at t: new `sout` from t+1.
- Final sample at t: `done`=1 and `rx_data` valid during t+1 only for `done`; `busy`=0 and `load_ready`=1 from t+1.
- A back-to-back load in cycle t+1 is allowed and accepted at edge t+1.
- Strobes are single-cycle qualifiers; a strobe held high for k cycles counts as k events.
- Reset mid-frame: everything returns to reset values at the next edge.

## Structure
- Shared package `i2c_pkg`: state enum `shift_state_t` {IDLE, ACTIVE} and the `CW` width function.
- One sub-module, `shift_bit_counter`, containing the load/decrement/last-bit counter. It is parametrised by `CW` and outputs `last` (cnt==1).
- Datapath mux (head select, masked shift) stays in `shift_engine`.

## Test plan
- Reset asserted 2 cycles → `sout`=1, `load_ready`=1, `busy`=0, `done`=0, `rx_data`=0x00.
- WIDTH=8, load 0xA5, nbits=8, msb_first=1:
  - Alternate drive/sample for 8 bits with `sin` bits of 0x3C MSB-first.
  - → `sout` sequence 1,0,1,0,0,1,0,1.
  - → `done` one cycle after the 8th sample; `rx_data`=0x3C; `load_ready`=1 that cycle.
- Load 0x0F, nbits=8, msb_first=0:
  - Feed `sin` = bits of 0xC3 LSB-first.
  - → `sout` 1,1,1,1,0,0,0,0.
  - → `rx_data`=0xC3.
- ACK frame: load 0x00, nbits=1:
  - → `sout`=0 the cycle after load.
  - One sample with `sin`=1 → `done` next cycle; `rx_data`=0x01.
- Abort after 3 samples → `busy`=0 next cycle, no `done`, `rx_data` keeps its prior value. Abort with `load_valid` in IDLE → `load_ready`=0, frame not accepted.
- nbits=0 behaves as 8 (8 samples to `done`). `load_valid` while ACTIVE → not accepted, frame unchanged. Simultaneous drive+sample → `sout` equals the post-shift head.
